// File: rtl/fifo_pkg.sv
// Shared defaults and types for the sync_fifo slice.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 16;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef logic [7:0] data_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer port bundle for sync_fifo; strobes are active-low.
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_n;
  logic                  rd_n;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  over_flow;
  logic                  under_flow;

  modport master (
    output data_in,
    output wr_n,
    output rd_n,
    input  data_out,
    input  over_flow,
    input  under_flow
  );

  modport slave (
    input  data_in,
    input  wr_n,
    input  rd_n,
    output data_out,
    output over_flow,
    output under_flow
  );

endinterface

// File: rtl/fifo_ram.sv
// Register-array storage with one synchronous write port and one registered read port.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; a same-edge write to rd_addr is seen next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with active-low strobes, registered read data and per-cycle error flags.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_if.slave      bus
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH + 1)'(1);

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic [ADDR_WIDTH:0] count;
  logic                full;
  logic                empty;
  logic                rd_ok;
  logic                wr_ok;
  logic                over_flow_q;
  logic                under_flow_q;

  // Pointers carry a wrap bit, so their difference is the occupancy 0..DEPTH.
  assign count = wptr - rptr;
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A read on a full FIFO frees the slot the simultaneous write lands in.
  assign rd_ok = !bus.rd_n && !empty;
  assign wr_ok = !bus.wr_n && (!full || rd_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      over_flow_q  <= 1'b0;
      under_flow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rptr <= rptr + PTR_ONE;
      end
      over_flow_q  <= !bus.wr_n && !wr_ok;
      under_flow_q <= !bus.rd_n && !rd_ok;
    end
  end

  assign bus.over_flow  = over_flow_q;
  assign bus.under_flow = under_flow_q;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_addr (wptr[ADDR_WIDTH-1:0]),
    .wr_data (bus.data_in),
    .rd_en   (rd_ok),
    .rd_addr (rptr[ADDR_WIDTH-1:0]),
    .rd_data (bus.data_out)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: fill/drain, overflow, underflow, simultaneous access, async reset.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  sync_fifo_if bus ();

  sync_fifo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkSig(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input data_t expData, input logic expOf,
                             input logic expUf);
    checkSig({tag, ".data_out"}, bus.data_out, expData);
    checkSig({tag, ".over_flow"}, {7'b0, bus.over_flow}, {7'b0, expOf});
    checkSig({tag, ".under_flow"}, {7'b0, bus.under_flow}, {7'b0, expUf});
  endtask

  // Drive strobes between edges, let one rising edge sample them, then return to idle.
  task automatic applyStimulus(input logic wrN, input logic rdN, input data_t din);
    @(negedge clk);
    bus.wr_n    = wrN;
    bus.rd_n    = rdN;
    bus.data_in = din;
    @(posedge clk);
    #1;
    bus.wr_n = 1'b1;
    bus.rd_n = 1'b1;
  endtask

  initial begin
    bus.wr_n    = 1'b1;
    bus.rd_n    = 1'b1;
    bus.data_in = '0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(16 - i));
      checkOutput("fill", 8'h00, 1'b0, 1'b0);
    end

    applyStimulus(1'b0, 1'b1, 8'h01);
    checkOutput("ovf1", 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h01);
    checkOutput("ovf2", 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h00);
    checkOutput("ovf_clear", 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("drain", 8'(16 - i), 1'b0, 1'b0);
    end

    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("udf1", 8'h01, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("udf2", 8'h01, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h00);
    checkOutput("udf_clear", 8'h01, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("wr0", 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h01);
    checkOutput("wr1", 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("rd0", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("rd1", 8'h01, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 8'h02);
    checkOutput("wr2", 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h03);
    checkOutput("wr3", 8'h01, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h08);
    checkOutput("sim_mid", 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("rd3", 8'h03, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("rd8", 8'h08, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("sim_mid_empty", 8'h08, 1'b0, 1'b1);

    // Full FIFO with simultaneous read and write: count must stay at DEPTH.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h20 + i));
      checkOutput("fill2", 8'h08, 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 8'hAA);
    checkOutput("sim_full", 8'h20, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h55);
    checkOutput("sim_full_still_full", 8'h20, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("drain2", 8'(8'h20 + i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("drain2_last", 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("drain2_empty", 8'hAA, 1'b0, 1'b1);

    // Empty FIFO with simultaneous read and write: no bypass.
    applyStimulus(1'b0, 1'b0, 8'h5C);
    checkOutput("sim_empty", 8'hAA, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("sim_empty_rd", 8'h5C, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("sim_empty_udf", 8'h5C, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h11 + i));
      checkOutput("pre_rst_wr", 8'h5C, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("pre_rst_rd", 8'h11, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_rst", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("post_rst_rd", 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h77);
    checkOutput("post_rst_wr", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("post_rst_rd2", 8'h77, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, 16-entry by 8-bit first-in-first-out buffer with active-low read and write strobes.
- Registered read data output.
- Registered overflow and underflow error flags that report rejected writes and rejected reads.
- Used as a generic buffering block between a producer and a consumer in the same clock domain; it is also the target of the team's assertion-based checks.

Parameters:
- DATA_WIDTH, 8, width of data_in and data_out.
- DEPTH, 16, number of storage entries. Must be a power of two.
- ADDR_WIDTH, 4, log2(DEPTH), width of the read and write pointers (without the wrap bit).

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  write data, sampled on the rising clk edge when wr_n=0.
- wr_n  input  1  active-low write request.
- rd_n  input  1  active-low read request.
- data_out  output  DATA_WIDTH  registered read data.
- over_flow  output  1  registered: a write was rejected at the last edge because the FIFO was full.
- under_flow  output  1  registered: a read was rejected at the last edge because the FIFO was empty.

Behaviour:
- Reset (rst=1, asynchronous, takes effect immediately):
  - write pointer, read pointer and count cleared to 0;
  - data_out=0, over_flow=0, under_flow=0;
  - storage contents are don't-care.
  - Reset asserted mid-operation discards all entries. The first read after reset release therefore underflows.
- full is asserted when count==DEPTH; empty is asserted when count==0. These are internal signals only.
  - Pointers are ADDR_WIDTH+1 bits; full/empty may be derived from them or from a count register.
  - Pointers wrap modulo DEPTH with no gap.
- Write accepted (wr_n=0 and not full, or wr_n=0 and full with a simultaneous accepted read):
  - mem[wptr] <= data_in;
  - wptr increments.
- Read accepted (rd_n=0 and not empty):
  - data_out <= mem[rptr] on the same rising edge;
  - rptr increments.
  - Read latency is one edge: data is valid after the edge at which rd_n was sampled low.
- data_out holds its last value when there is no accepted read, including a rejected read.
- Rejected write (wr_n=0 and full and no accepted read):
  - data is dropped, memory and pointers unchanged;
  - over_flow <= 1 at that edge.
- Rejected read (rd_n=0 and empty):
  - data_out and pointers unchanged;
  - under_flow <= 1 at that edge.
- Flag clearing:
  - over_flow <= 0 at any edge without a rejected write.
  - under_flow <= 0 at any edge without a rejected read.
  - Flags are per-cycle status, not sticky. Back-to-back rejected attempts hold the flag high continuously.
- Simultaneous rd_n=0 and wr_n=0:
  - Not empty and not full: both accepted, count unchanged.
  - Full: both accepted (read frees the slot), count stays DEPTH, over_flow=0.
  - Empty: write accepted, read rejected (no bypass), under_flow=1, count becomes 1, data_out unchanged.
- Inputs are sampled only at the rising edge; no combinational path from any input to any output.

Decomposition:
- Shared package fifo_pkg holds DATA_WIDTH_DEF=8, DEPTH_DEF=16, ADDR_WIDTH_DEF=4 and typedef data_t (logic [7:0]).
- Optional sub-module fifo_ram: DEPTH x DATA_WIDTH register array with one synchronous write port and one synchronous read port.
- Pointer, count and flag logic stay in sync_fifo.

Test Plan:
- Reset for 3 cycles, then write 16,15,...,1 on 16 consecutive edges -> over_flow=0, under_flow=0 throughout; FIFO full.
- While full, write 1 twice -> over_flow=1 after each of those edges; contents unchanged; over_flow returns to 0 on the next idle or read edge.
- Read 16 times -> data_out sequence 16,15,...,1, each valid after its read edge; under_flow=0.
- While empty, read twice -> under_flow=1, data_out holds 1.
- Write 0, write 1, read, read -> data_out 0 then 1.
- Write 2, write 3, then simultaneous write 8 and read -> data_out=2, count=2, no flags. Next two reads return 3 then 8.
- Mid-stream rst=1 pulse after 5 writes -> outputs 0 immediately; the following read gives under_flow=1.
